// File: rtl/display_scan.sv
// Four-digit multiplexed display driver: a double-dabble converter turns a
// 14-bit binary load into BCD, and a prescaled scanner walks the anodes.
module display_scan #(
  parameter int SCAN_DIV = 50000,
  parameter int BLANK_LZ = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [13:0] value,
  input  logic        load,
  output logic        busy,
  output logic [3:0]  bcd,
  output logic [3:0]  an
);

  typedef enum logic [1:0] {IDLE, CONV, DONE} state_t;

  localparam logic [19:0] PRESC_MAX = 20'(SCAN_DIV - 1);

  state_t      state_q, state_d;
  logic [13:0] shift_q, shift_d;
  logic [15:0] acc_q, acc_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        err_q, err_d;
  logic [15:0] disp_q, disp_d;
  logic [19:0] presc_q, presc_d;
  logic [1:0]  idx_q, idx_d;
  logic [3:0]  bcd_q, bcd_d;
  logic [3:0]  an_q, an_d;
  logic [15:0] adj;
  logic        blank;

  always_comb begin
    adj = acc_q;
    for (int i = 0; i < 4; i++) begin
      if (acc_q[4*i +: 4] >= 4'd5) begin
        adj[4*i +: 4] = acc_q[4*i +: 4] + 4'd3;
      end
    end
  end

  // Conversion FSM; the display register only changes in DONE.
  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    disp_d  = disp_q;
    case (state_q)
      IDLE: begin
        if (load) begin
          shift_d = value;
          acc_d   = 16'h0000;
          cnt_d   = 4'd0;
          err_d   = (value > 14'd9999);
          state_d = CONV;
        end
      end
      CONV: begin
        acc_d   = (adj << 1) | {15'b0, shift_q[13]};
        shift_d = {shift_q[12:0], 1'b0};
        cnt_d   = cnt_q + 4'd1;
        if (cnt_q == 4'd13) begin
          state_d = DONE;
        end
      end
      DONE: begin
        disp_d  = err_q ? 16'hEEEE : acc_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Scan outputs are computed from the next index so bcd and an move together.
  always_comb begin
    presc_d = (presc_q == PRESC_MAX) ? 20'd0 : presc_q + 20'd1;
    idx_d   = (presc_q == PRESC_MAX) ? idx_q + 2'd1 : idx_q;
    bcd_d   = disp_q[3:0];
    blank   = 1'b0;
    case (idx_d)
      2'd0: bcd_d = disp_q[3:0];
      2'd1: begin
        bcd_d = disp_q[7:4];
        blank = (disp_q[15:4] == 12'h000);
      end
      2'd2: begin
        bcd_d = disp_q[11:8];
        blank = (disp_q[15:8] == 8'h00);
      end
      default: begin
        bcd_d = disp_q[15:12];
        blank = (disp_q[15:12] == 4'h0);
      end
    endcase
    if (BLANK_LZ == 0) begin
      blank = 1'b0;
    end
    an_d = blank ? 4'b1111 : ~(4'b0001 << idx_d);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      shift_q <= 14'd0;
      acc_q   <= 16'h0000;
      cnt_q   <= 4'd0;
      err_q   <= 1'b0;
      disp_q  <= 16'h0000;
      presc_q <= 20'd0;
      idx_q   <= 2'd0;
      bcd_q   <= 4'h0;
      an_q    <= 4'b1110;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      disp_q  <= disp_d;
      presc_q <= presc_d;
      idx_q   <= idx_d;
      bcd_q   <= bcd_d;
      an_q    <= an_d;
    end
  end

  assign busy = (state_q != IDLE);
  assign bcd  = bcd_q;
  assign an   = an_q;

endmodule

// File: tb/tb_display_scan.sv
// Directed bench for display_scan: conversion timing, scan order, blanking,
// load collisions and reset abort, with two instances differing in BLANK_LZ.
module tb_display_scan;

  logic        clk = 1'b0;
  logic        rst;
  logic        load;
  logic [13:0] value;
  logic        busy, busyB;
  logic [3:0]  bcd, an, bcdB, anB;
  logic        useB = 1'b0;
  int          asserts = 0;
  int          failures = 0;

  always #5 clk = ~clk;

  display_scan #(.SCAN_DIV(4), .BLANK_LZ(1)) dut (
    .clk(clk), .rst(rst), .value(value), .load(load),
    .busy(busy), .bcd(bcd), .an(an)
  );

  display_scan #(.SCAN_DIV(4), .BLANK_LZ(0)) dutNoBlank (
    .clk(clk), .rst(rst), .value(value), .load(load),
    .busy(busyB), .bcd(bcdB), .an(anB)
  );

  task automatic checkOutput(input string tag, input logic [15:0] got, input logic [15:0] exp);
    asserts++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic applyStimulus(input logic [13:0] v);
    @(negedge clk);
    value = v;
    load  = 1'b1;
    @(negedge clk);
    load  = 1'b0;
  endtask

  task automatic loadAndSettle(input logic [13:0] v);
    applyStimulus(v);
    repeat (20) @(negedge clk);
  endtask

  // Locks onto the start of the units slot, then checks one slot per 4 clocks.
  task automatic scanCheck(input string tag, input logic [15:0] expBcd, input logic [15:0] expAn);
    logic [3:0] prevAn, curAn, curBcd;
    bit found;
    found  = 1'b0;
    prevAn = useB ? anB : an;
    for (int i = 0; i < 40 && !found; i++) begin
      @(negedge clk);
      curAn = useB ? anB : an;
      if (curAn == 4'b1110 && prevAn != 4'b1110) found = 1'b1;
      prevAn = curAn;
    end
    checkOutput({tag, " sync"}, {15'b0, found}, 16'd1);
    if (found) begin
      for (int k = 0; k < 4; k++) begin
        curBcd = useB ? bcdB : bcd;
        curAn  = useB ? anB : an;
        checkOutput($sformatf("%s bcd slot%0d", tag, k), {12'b0, curBcd}, {12'b0, expBcd[4*k +: 4]});
        checkOutput($sformatf("%s an slot%0d", tag, k), {12'b0, curAn}, {12'b0, expAn[4*k +: 4]});
        if (k < 3) repeat (4) @(negedge clk);
      end
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int bad, blanks, eights;
    rst   = 1'b1;
    load  = 1'b0;
    value = 14'd0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("reset bcd", {12'b0, bcd}, 16'h0000);
    checkOutput("reset an", {12'b0, an}, 16'h000E);
    checkOutput("reset busy", {15'b0, busy}, 16'd0);
    rst = 1'b0;

    bad = 0;
    blanks = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (an != 4'b1110 && an != 4'b1111) bad++;
      if (an == 4'b1111) blanks++;
    end
    checkOutput("idle scan non-units anode", 16'(bad), 16'd0);
    checkOutput("idle scan blank slots seen", {15'b0, (blanks > 0)}, 16'd1);

    $display("[TB] conversion of 1234");
    checkOutput("busy before load", {15'b0, busy}, 16'd0);
    applyStimulus(14'd1234);
    checkOutput("busy cycle1", {15'b0, busy}, 16'd1);
    repeat (14) @(negedge clk);
    checkOutput("busy cycle15", {15'b0, busy}, 16'd1);
    @(negedge clk);
    checkOutput("busy cycle16", {15'b0, busy}, 16'd0);
    scanCheck("v1234", 16'h1234, 16'h7BDE);

    loadAndSettle(14'd9999);
    scanCheck("v9999", 16'h9999, 16'h7BDE);
    loadAndSettle(14'd10000);
    scanCheck("v10000", 16'hEEEE, 16'h7BDE);
    loadAndSettle(14'd0);
    scanCheck("v0", 16'h0000, 16'hFFFE);

    loadAndSettle(14'd705);
    scanCheck("v705", 16'h0705, 16'hFBDE);
    useB = 1'b1;
    scanCheck("v705 noblank", 16'h0705, 16'h7BDE);
    useB = 1'b0;

    $display("[TB] load collision");
    applyStimulus(14'd42);
    repeat (3) @(negedge clk);
    value = 14'd99;
    load  = 1'b1;
    @(negedge clk);
    load  = 1'b0;
    checkOutput("busy during collision", {15'b0, busy}, 16'd1);
    repeat (20) @(negedge clk);
    scanCheck("v42 collision", 16'h0042, 16'hFFDE);
    loadAndSettle(14'd99);
    scanCheck("v99", 16'h0099, 16'hFFDE);

    $display("[TB] mid-conversion reset");
    applyStimulus(14'd8888);
    repeat (6) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checkOutput("abort busy", {15'b0, busy}, 16'd0);
    checkOutput("abort an", {12'b0, an}, 16'h000E);
    checkOutput("abort bcd", {12'b0, bcd}, 16'h0000);
    eights = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bcd == 4'h8) eights++;
    end
    checkOutput("abort no 8888 digits", 16'(eights), 16'd0);
    scanCheck("v0 after abort", 16'h0000, 16'hFFFE);

    $display("End of test - %0d assertions evaluated, %0d failures", asserts, failures);
    $finish;
  end

endmodule

// File: doc/display_scan.md
DISPLAY_SCAN -- requirements
Module: display_scan

Interface
REQ-001 Parameter: SCAN_DIV, default 50000, clock cycles per digit slot (1 kHz per digit at 50 MHz); legal range 2..2^20-1.
REQ-002 Parameter: BLANK_LZ, default 1, 1 = suppress leading zeros, 0 = show all four digits.
REQ-003 Port: clk  input  1  single system clock; all logic on rising edge.
REQ-004 Port: rst  input  1  synchronous, active-high reset.
REQ-005 Port: value  input  14  unsigned binary number to display.
REQ-006 Port: load  input  1  one-cycle strobe; sample value and start conversion.
REQ-007 Port: busy  output  1  high while a conversion is in progress.
REQ-008 Port: bcd  output  4  nibble for the currently scanned digit; feeds the BCD-to-7-segment decoder.
REQ-009 Port: an  output  4  active-low one-hot anode select; an[0] = units, an[3] = thousands.

Function
REQ-010 The block SHALL contain a 4-digit display register D3..D0 (16 bits) that drives the scan; only a completed conversion SHALL write it.
REQ-011 FSM states SHALL be IDLE, CONV and DONE.
- IDLE -> CONV on load.
- CONV -> DONE after 14 shift cycles.
- DONE -> IDLE unconditionally after 1 cycle.
REQ-012 A load in IDLE SHALL latch value into a shift register and clear the BCD accumulator.
REQ-013 busy SHALL be high from the cycle after the accepted load through the DONE cycle inclusive.
REQ-014 A load while busy=1 SHALL be ignored, with no restart and no queueing.
REQ-015 CONV SHALL perform one double-dabble step per clock: add 3 to every accumulator nibble >= 5, then shift left one bit, bringing in the MSB of the binary shift register.
REQ-016 In DONE, if the latched value <= 9999 the accumulator SHALL be written to D3..D0; otherwise D3..D0 SHALL be written 4'hE,4'hE,4'hE,4'hE (error display).
REQ-017 The display register SHALL update exactly 16 clocks after the load edge: 1 accept + 14 CONV + 1 DONE.
REQ-018 The old contents SHALL stay displayed until that update.
REQ-019 A prescaler SHALL count 0..SCAN_DIV-1 continuously, independent of the FSM, and wrap to 0.
REQ-020 On prescaler terminal count, the digit index SHALL advance 0->1->2->3->0 (2-bit wrap).
REQ-021 bcd SHALL equal D[index] and an SHALL equal ~(4'b0001 << index).
- Both are registered and change on the same clock edge.
REQ-022 Leading-zero blanking, BLANK_LZ=1: digit k (k = 3..1) SHALL be blank when D3..Dk are all zero.
- Digit 0 is never blanked.
- A blank slot drives an = 4'b1111; bcd still shows D[index].
- The slot timing is unchanged.
REQ-023 The error pattern (4'hE) SHALL never be blanked.
REQ-024 With BLANK_LZ=0, no digit SHALL be blanked.
REQ-025 At most one an bit SHALL be low in any cycle, including across index wrap.

Reset
REQ-026 When rst=1 at a clock edge, the block SHALL force:
- state = IDLE, busy = 0;
- prescaler = 0, index = 0;
- D3..D0 = 0;
- shift and accumulator registers = 0;
- bcd = 4'h0, an = 4'b1110.
REQ-027 rst SHALL take priority over load.
REQ-028 rst during CONV or DONE SHALL abort the conversion, leave D3..D0 = 0 and discard the pending result.
REQ-029 After rst is released, the first load SHALL be accepted in the first cycle it is asserted.

Verification
REQ-030 The bench SHALL use SCAN_DIV=4, BLANK_LZ=1 unless noted, and cover:
- Reset: assert rst 2 cycles -> bcd=0, an=4'b1110, busy=0; hold 20 cycles -> an cycles 1110 only (digits 3..1 blank, an=1111 in their slots).
- Conversion: load with value=1234 -> busy high cycles 1..15; D=1,2,3,4 at cycle 16; scan shows bcd 4,3,2,1 with an 1110,1101,1011,0111, 4 clocks each.
- Boundaries: value=9999 -> all digits 9, none blank; value=10000 -> all digits 4'hE, none blank; value=0 -> only units shown, bcd=0.
- Blanking: value=705 -> thousands slot an=1111; hundreds 7, tens 0 (shown), units 5. With BLANK_LZ=0, thousands shows 0 with an=0111.
- Load collision: load 42 and then load 99 at cycle 5 -> 99 ignored, display 0042 (blanked to "42"); a subsequent load 99 in IDLE -> display 99.
- Mid-conversion reset: load 8888, assert rst at cycle 8 -> D=0, busy=0, an=1110, and 8888 never appears.
